// File: rtl/ysyx_22050612_mem_arbiter.sv
// rtl/ysyx_22050612_mem_arbiter.sv - IFU/LSU arbiter for the shared 64-bit data-memory port
// One transaction in flight; the LSU wins contention until its streak limit lets a fetch through.
module ysyx_22050612_mem_arbiter #(
  parameter int unsigned MAX_LSU_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [63:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [63:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [63:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [63:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [63:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LSU_STREAK);

  state_e      state_q;
  logic        owner_q;
  logic [3:0]  streak_q, streak_d;
  logic        mem_req_valid_q, mem_wen_q;
  logic [63:0] mem_addr_q, mem_wdata_q;
  logic [7:0]  mem_wmask_q;
  logic        ifu_resp_valid_q, lsu_resp_valid_q;
  logic [63:0] ifu_rdata_q, lsu_rdata_q;
  logic        idle, ifu_turn, grant_ifu, grant_lsu;

  // The IFU wins when it is alone or when the LSU has used up its streak.
  assign idle      = (state_q == S_IDLE) && !rst;
  assign ifu_turn  = !lsu_req_valid || (streak_q == STREAK_MAX);
  assign grant_ifu = idle && ifu_req_valid && ifu_turn;
  assign grant_lsu = idle && lsu_req_valid && !(ifu_req_valid && ifu_turn);

  always_comb begin
    streak_d = streak_q;
    if (grant_ifu) begin
      streak_d = '0;
    end else if (grant_lsu) begin
      if (!ifu_req_valid) begin
        streak_d = '0;
      end else if (streak_q != 4'hf) begin
        streak_d = streak_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      owner_q          <= 1'b0;
      streak_q         <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_wen_q        <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_wmask_q      <= '0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      ifu_rdata_q      <= '0;
      lsu_rdata_q      <= '0;
    end else begin
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_ifu || grant_lsu) begin
            state_q         <= S_REQ;
            owner_q         <= grant_lsu;
            streak_q        <= streak_d;
            mem_req_valid_q <= 1'b1;
            mem_addr_q      <= grant_lsu ? lsu_addr : ifu_addr;
            mem_wen_q       <= grant_lsu && lsu_wen;
            mem_wdata_q     <= grant_lsu ? lsu_wdata : '0;
            mem_wmask_q     <= (grant_lsu && lsu_wen) ? lsu_wmask : 8'h00;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state_q         <= S_RESP;
            mem_req_valid_q <= 1'b0;
          end
        end
        S_RESP: begin
          if (mem_resp_valid) begin
            state_q <= S_IDLE;
            if (owner_q) begin
              lsu_resp_valid_q <= 1'b1;
              lsu_rdata_q      <= mem_wen_q ? 64'd0 : mem_rdata;
            end else begin
              ifu_resp_valid_q <= 1'b1;
              ifu_rdata_q      <= mem_rdata;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ifu_req_ready  = grant_ifu;
  assign lsu_req_ready  = grant_lsu;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_rdata      = lsu_rdata_q;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wen        = mem_wen_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wmask      = mem_wmask_q;

endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
Name: ysyx_22050612_mem_arbiter

Overview:
- Shares the single 64-bit data-memory port (behind the pmem_read/pmem_write DPI wrapper) between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle core.
- Grants one requester at a time and registers its request.
- Drives a valid/ready request channel to memory, waits for the response, then routes it back to the owner.
- Contains a starvation limiter so a run of LSU accesses cannot block instruction fetch indefinitely.

Parameters:
- MAX_LSU_STREAK, 4: number of consecutive LSU grants allowed while the IFU is waiting; the next contested grant then goes to the IFU. Legal range 1..15.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  one-cycle pulse: IFU request accepted this cycle
- ifu_addr  in  64  fetch address (8-byte aligned)
- ifu_resp_valid  out  1  one-cycle pulse: ifu_rdata valid
- ifu_rdata  out  64  fetched doubleword
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  one-cycle pulse: LSU request accepted this cycle
- lsu_addr  in  64  access address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  64  write data, pre-aligned to lanes
- lsu_wmask  in  8  byte-lane write mask
- lsu_resp_valid  out  1  one-cycle pulse: read data or write acknowledge
- lsu_rdata  out  64  read doubleword; 0 for writes
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_addr  out  64  registered address
- mem_wen  out  1  registered write enable
- mem_wdata  out  64  registered write data
- mem_wmask  out  8  registered mask; 8'h00 for reads
- mem_resp_valid  in  1  memory response / write acknowledge
- mem_rdata  in  64  memory read data

Behaviour:
- States:
  - IDLE: arbitrate.
  - REQ: mem_req_valid=1, wait for mem_req_ready.
  - RESP: wait for mem_resp_valid.
- Owner register: 0 = IFU, 1 = LSU.
- Arbitration in IDLE, combinational on the valids:
  - Only one valid: grant it.
  - Both valid: grant LSU unless streak == MAX_LSU_STREAK, in which case grant IFU.
  - The granted req_ready pulses in the same cycle.
  - Address, wen, wdata and wmask are latched into the mem_* registers; state goes to REQ.
  - IFU grants force mem_wen=0 and mem_wmask=0.
- Streak counter, 4 bits:
  - LSU grant while ifu_req_valid=1: increment, saturating.
  - LSU grant with ifu_req_valid=0: clear.
  - IFU grant: clear.
- REQ:
  - mem_req_valid is held high with stable mem_* fields until mem_req_ready=1, then state goes to RESP.
  - mem_resp_valid is ignored in REQ.
- RESP:
  - On mem_resp_valid, the owner's resp_valid pulses for exactly one cycle in the next cycle.
  - The owner's rdata is registered at the same time: mem_rdata for reads, 0 for LSU writes.
  - State returns to IDLE in that same next cycle.
- Minimum round trip with a memory that has ready=1 and 1-cycle response:
  - cycle 0: grant.
  - cycle 1: REQ handshake.
  - cycle 2: mem_resp_valid.
  - cycle 3: resp_valid at the requester and IDLE; a new grant is possible in cycle 3.
- Requesters hold valid and payload until their ready pulse. Only one outstanding transaction exists at a time; ready is never asserted outside IDLE.
- mem_resp_valid in IDLE (stale response) is dropped; no resp pulse is generated.
- Reset:
  - All outputs 0, state IDLE, streak 0, owner 0.
  - Reset mid-transaction abandons it silently; the late memory response is dropped as stale.
  - Reset has priority over every other event in the same cycle.
- rdata outputs hold their last value between pulses.

Test Plan:
- Single IFU read:
  - Stimulus: ifu_req_valid with addr 0x80000000; memory ready=1, returns 0x00100073_00000413 one cycle after handshake.
  - Response: ifu_req_ready in cycle 0, mem_req_valid in cycle 1, ifu_resp_valid in cycle 3 with that data; lsu_resp_valid stays 0.
- LSU write:
  - Stimulus: lsu_wen=1, addr 0x80001004, wdata 0xdeadbeef00000000, wmask 8'hf0.
  - Response: mem_* fields match exactly; lsu_resp_valid pulses once with lsu_rdata=0.
- Contention with MAX_LSU_STREAK=4:
  - Stimulus: both valids held high continuously.
  - Response: grant order LSU, LSU, LSU, LSU, IFU, LSU…; streak returns to 0 after the IFU grant.
- Backpressure:
  - Stimulus: mem_req_ready held low for 5 cycles.
  - Response: mem_req_valid and mem_addr/wdata/wmask stay stable for all 5 cycles; no ready pulses occur to either requester.
- Reset and stale response:
  - Stimulus: assert rst in RESP state; a stale mem_resp_valid arrives 2 cycles after reset deasserts.
  - Response: no resp_valid on either side; the arbiter grants a new IFU request normally.
- Simultaneous single-valid edge:
  - Stimulus: lsu_req_valid only, with streak at 4 from earlier contention.
  - Response: LSU is granted and the streak clears to 0.
